// File: rtl/fofb_cell_tracker.sv
// fofb_cell_tracker
// Merges cell-status beats from NUM_LINKS links with a round-robin arbiter and
// tracks which cells arrive in each fast-acquisition (FA) cycle. Each cycle ends
// either complete (all expected cells seen) or timed out. The tracker also keeps
// per-link success counts and end-of-cycle snapshots for the CSR readout.
module fofb_cell_tracker #(
  parameter int SYSCLK_RATE      = 100000000,
  parameter int NUM_LINKS        = 2,
  parameter int MAX_CELLS        = 32,
  parameter int CELL_INDEX_WIDTH = (MAX_CELLS > 1) ? $clog2(MAX_CELLS) : 1,
  parameter int CELL_COUNT_WIDTH = $clog2(MAX_CELLS + 1),
  parameter int LINK_INDEX_WIDTH = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1,
  parameter int TIMER_WIDTH      = 8,
  parameter int SEQNO_WIDTH      = 3
) (
  input  logic                                      sysClk,
  input  logic                                      sysReset,
  input  logic                                      FAstrobe,
  input  logic [CELL_COUNT_WIDTH-1:0]               cellCount,
  input  logic [TIMER_WIDTH-1:0]                    timeoutLimit,
  input  logic [NUM_LINKS-1:0]                      linkInhibit,
  input  logic [NUM_LINKS-1:0]                      statusTVALID,
  output logic [NUM_LINKS-1:0]                      statusTREADY,
  input  logic [NUM_LINKS*(CELL_INDEX_WIDTH+2)-1:0] statusTDATA,
  input  logic [NUM_LINKS-1:0]                      statusTUSER,
  output logic                                      mergedStrobe,
  output logic [LINK_INDEX_WIDTH-1:0]               mergedLink,
  output logic [1:0]                                mergedCode,
  output logic                                      readoutActive,
  output logic                                      readoutValid,
  output logic                                      readTimeout,
  output logic                                      timeoutStrobe,
  output logic                                      fofbEnabled,
  output logic [TIMER_WIDTH-1:0]                    readoutTime,
  output logic [SEQNO_WIDTH-1:0]                    seqno,
  output logic [CELL_COUNT_WIDTH-1:0]               cellCounter,
  output logic [MAX_CELLS-1:0]                      fofbBitmapAll,
  output logic [MAX_CELLS-1:0]                      fofbBitmapEnabled,
  output logic [MAX_CELLS-1:0]                      fofbBitmapAllSnapshot,
  output logic [MAX_CELLS-1:0]                      fofbBitmapEnabledSnapshot,
  output logic [NUM_LINKS*CELL_COUNT_WIDTH-1:0]     linkPacketCount
);

  localparam int STATUS_WIDTH = CELL_INDEX_WIDTH + 2;
  // Lane arrays are padded to a power of two so any grant index value is a legal select.
  localparam int LINK_SLOTS   = 1 << LINK_INDEX_WIDTH;
  localparam int US_RELOAD    = SYSCLK_RATE / 1000000 - 1;
  localparam int DIV_WIDTH    = (US_RELOAD > 0) ? $clog2(US_RELOAD + 1) : 1;

  // (base + offset) modulo NUM_LINKS, for offsets 0..NUM_LINKS-1.
  function automatic logic [LINK_INDEX_WIDTH-1:0] wrap_link(input int base, input int offset);
    int sum;
    sum = base + offset;
    if (sum >= NUM_LINKS) sum = sum - NUM_LINKS;
    return LINK_INDEX_WIDTH'(sum);
  endfunction

  // ---------------------------------------------------------------------------
  // Per-link lane decode
  // ---------------------------------------------------------------------------
  logic [LINK_SLOTS-1:0]       eligible;
  logic [LINK_SLOTS-1:0]       lane_user;
  logic [1:0]                  lane_code  [LINK_SLOTS];
  logic [CELL_INDEX_WIDTH-1:0] lane_index [LINK_SLOTS];

  genvar gi;
  generate
    for (gi = 0; gi < LINK_SLOTS; gi++) begin : g_lane
      if (gi < NUM_LINKS) begin : g_real
        assign eligible[gi]   = statusTVALID[gi] & ~linkInhibit[gi];
        assign lane_user[gi]  = statusTUSER[gi];
        assign lane_index[gi] = statusTDATA[gi*STATUS_WIDTH +: CELL_INDEX_WIDTH];
        assign lane_code[gi]  = statusTDATA[gi*STATUS_WIDTH + CELL_INDEX_WIDTH +: 2];
      end else begin : g_pad
        assign eligible[gi]   = 1'b0;
        assign lane_user[gi]  = 1'b0;
        assign lane_index[gi] = '0;
        assign lane_code[gi]  = 2'b00;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round-robin arbiter
  // ---------------------------------------------------------------------------
  logic [LINK_INDEX_WIDTH-1:0] rr_ptr_q;
  logic                        grant_valid;
  logic [LINK_INDEX_WIDTH-1:0] grant_idx;
  logic                        transfer;

  // Pick the first eligible link at or after rr_ptr_q; the smallest offset wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_LINKS - 1; k >= 0; k--) begin
      if (eligible[wrap_link(int'(rr_ptr_q), k)]) begin
        grant_valid = 1'b1;
        grant_idx   = wrap_link(int'(rr_ptr_q), k);
      end
    end
  end

  assign transfer = grant_valid & ~sysReset;

  // Inhibited links are always drained; otherwise only the granted link is ready.
  generate
    for (gi = 0; gi < NUM_LINKS; gi++) begin : g_ready
      assign statusTREADY[gi] = ~sysReset &
                                (linkInhibit[gi] | (grant_valid & (grant_idx == LINK_INDEX_WIDTH'(gi))));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Merged beat stage
  // ---------------------------------------------------------------------------
  logic                        merged_strobe_q;
  logic [LINK_INDEX_WIDTH-1:0] merged_link_q;
  logic [1:0]                  merged_code_q;
  logic [CELL_INDEX_WIDTH-1:0] merged_index_q;
  logic                        merged_user_q;

  // Register the granted beat and advance the round-robin pointer past it.
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      merged_strobe_q <= 1'b0;
      merged_link_q   <= '0;
      merged_code_q   <= 2'b00;
      merged_index_q  <= '0;
      merged_user_q   <= 1'b0;
      rr_ptr_q        <= '0;
    end else begin
      merged_strobe_q <= transfer;
      if (transfer) begin
        merged_link_q  <= grant_idx;
        merged_code_q  <= lane_code[grant_idx];
        merged_index_q <= lane_index[grant_idx];
        merged_user_q  <= lane_user[grant_idx];
        rr_ptr_q       <= wrap_link(int'(grant_idx), 1);
      end
    end
  end

  logic success_event;
  logic index_in_range;
  logic track_event;
  logic readout_active_q;

  assign success_event  = merged_strobe_q & (merged_code_q == 2'b00);
  assign index_in_range = (int'(merged_index_q) < MAX_CELLS);
  assign track_event    = success_event & index_in_range & readout_active_q;

  // ---------------------------------------------------------------------------
  // Per-link success counters
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NUM_LINKS; gi++) begin : g_link_count
      logic [CELL_COUNT_WIDTH-1:0] count_q;
      logic [CELL_COUNT_WIDTH-1:0] packet_q;

      // Saturating running count, published and cleared at each FA strobe.
      always_ff @(posedge sysClk) begin
        if (sysReset) begin
          count_q  <= '0;
          packet_q <= '0;
        end else if (FAstrobe) begin
          packet_q <= count_q;
          count_q  <= '0;
        end else if (success_event && (merged_link_q == LINK_INDEX_WIDTH'(gi)) && (count_q != '1)) begin
          count_q <= count_q + 1'b1;
        end
      end

      assign linkPacketCount[gi*CELL_COUNT_WIDTH +: CELL_COUNT_WIDTH] = packet_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Cycle tracker
  // ---------------------------------------------------------------------------
  logic                        readout_active_d;
  logic                        readout_valid_q,   readout_valid_d;
  logic                        read_timeout_q,    read_timeout_d;
  logic                        timeout_strobe_q,  timeout_strobe_d;
  logic                        fofb_enabled_q,    fofb_enabled_d;
  logic [TIMER_WIDTH-1:0]      readout_time_q,    readout_time_d;
  logic [SEQNO_WIDTH-1:0]      seqno_q,           seqno_d;
  logic [CELL_COUNT_WIDTH-1:0] cell_counter_q,    cell_counter_d;
  logic [CELL_COUNT_WIDTH-1:0] fofb_counter_q,    fofb_counter_d;
  logic [MAX_CELLS-1:0]        bitmap_all_q,      bitmap_all_d;
  logic [MAX_CELLS-1:0]        bitmap_en_q,       bitmap_en_d;
  logic [MAX_CELLS-1:0]        snap_all_q,        snap_all_d;
  logic [MAX_CELLS-1:0]        snap_en_q,         snap_en_d;
  logic [DIV_WIDTH-1:0]        div_q,             div_d;
  logic [TIMER_WIDTH-1:0]      timer_q,           timer_d;
  logic                        completion;
  logic                        timeout_hit;

  // Completion is judged on registered counts, so it beats a same-cycle timeout.
  assign completion  = readout_active_q && (cell_counter_q == cellCount);
  assign timeout_hit = readout_active_q && (timeoutLimit != '0) &&
                       (timer_q >= timeoutLimit) && !completion;

  // Next-state logic: FA strobe restarts the cycle, otherwise track, time and close it.
  always_comb begin
    readout_active_d = readout_active_q;
    readout_valid_d  = readout_valid_q;
    read_timeout_d   = read_timeout_q;
    timeout_strobe_d = 1'b0;
    fofb_enabled_d   = fofb_enabled_q;
    readout_time_d   = readout_time_q;
    seqno_d          = seqno_q;
    cell_counter_d   = cell_counter_q;
    fofb_counter_d   = fofb_counter_q;
    bitmap_all_d     = bitmap_all_q;
    bitmap_en_d      = bitmap_en_q;
    snap_all_d       = snap_all_q;
    snap_en_d        = snap_en_q;
    div_d            = div_q;
    timer_d          = timer_q;

    if (FAstrobe) begin
      snap_all_d       = bitmap_all_q;
      snap_en_d        = bitmap_en_q;
      bitmap_all_d     = '0;
      bitmap_en_d      = '0;
      cell_counter_d   = '0;
      fofb_counter_d   = '0;
      readout_valid_d  = 1'b0;
      read_timeout_d   = 1'b0;
      timer_d          = '0;
      div_d            = DIV_WIDTH'(US_RELOAD);
      readout_active_d = 1'b1;
    end else if (readout_active_q) begin
      // Microsecond timebase
      if (div_q == '0) begin
        div_d = DIV_WIDTH'(US_RELOAD);
        if (timer_q != '1) timer_d = timer_q + 1'b1;
      end else begin
        div_d = div_q - 1'b1;
      end

      // Arrival bookkeeping; repeats of a cell leave the bitmaps and counters alone
      if (track_event) begin
        if (!bitmap_all_q[merged_index_q]) begin
          bitmap_all_d[merged_index_q] = 1'b1;
          cell_counter_d               = cell_counter_q + 1'b1;
        end
        if (merged_user_q && !bitmap_en_q[merged_index_q]) begin
          bitmap_en_d[merged_index_q] = 1'b1;
          fofb_counter_d              = fofb_counter_q + 1'b1;
        end
      end

      // End of cycle
      if (completion) begin
        readout_valid_d  = 1'b1;
        fofb_enabled_d   = (fofb_counter_q == cellCount);
        seqno_d          = seqno_q + 1'b1;
        readout_time_d   = timer_q;
        readout_active_d = 1'b0;
      end else if (timeout_hit) begin
        read_timeout_d   = 1'b1;
        timeout_strobe_d = 1'b1;
        fofb_enabled_d   = 1'b0;
        readout_time_d   = timer_q;
        readout_active_d = 1'b0;
      end
    end
  end

  // Tracker state registers.
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      readout_active_q <= 1'b0;
      readout_valid_q  <= 1'b0;
      read_timeout_q   <= 1'b0;
      timeout_strobe_q <= 1'b0;
      fofb_enabled_q   <= 1'b0;
      readout_time_q   <= '0;
      seqno_q          <= '0;
      cell_counter_q   <= '0;
      fofb_counter_q   <= '0;
      bitmap_all_q     <= '0;
      bitmap_en_q      <= '0;
      snap_all_q       <= '0;
      snap_en_q        <= '0;
      div_q            <= '0;
      timer_q          <= '0;
    end else begin
      readout_active_q <= readout_active_d;
      readout_valid_q  <= readout_valid_d;
      read_timeout_q   <= read_timeout_d;
      timeout_strobe_q <= timeout_strobe_d;
      fofb_enabled_q   <= fofb_enabled_d;
      readout_time_q   <= readout_time_d;
      seqno_q          <= seqno_d;
      cell_counter_q   <= cell_counter_d;
      fofb_counter_q   <= fofb_counter_d;
      bitmap_all_q     <= bitmap_all_d;
      bitmap_en_q      <= bitmap_en_d;
      snap_all_q       <= snap_all_d;
      snap_en_q        <= snap_en_d;
      div_q            <= div_d;
      timer_q          <= timer_d;
    end
  end

  assign mergedStrobe              = merged_strobe_q;
  assign mergedLink                = merged_link_q;
  assign mergedCode                = merged_code_q;
  assign readoutActive             = readout_active_q;
  assign readoutValid              = readout_valid_q;
  assign readTimeout               = read_timeout_q;
  assign timeoutStrobe             = timeout_strobe_q;
  assign fofbEnabled               = fofb_enabled_q;
  assign readoutTime               = readout_time_q;
  assign seqno                     = seqno_q;
  assign cellCounter               = cell_counter_q;
  assign fofbBitmapAll             = bitmap_all_q;
  assign fofbBitmapEnabled         = bitmap_en_q;
  assign fofbBitmapAllSnapshot     = snap_all_q;
  assign fofbBitmapEnabledSnapshot = snap_en_q;

endmodule

// File: tb/tb_fofb_cell_tracker.sv
// Directed bench for fofb_cell_tracker: a 2-link instance for tracking,
// completion, timeout, inhibit and reset, and a 4-link instance for arbitration.
module tb_fofb_cell_tracker;
  localparam int SW = 7;  // {code[1:0], cellIndex[4:0]}

  int checks = 0;
  int errors = 0;

  logic        sysClk = 1'b0;
  logic        sysReset = 1'b1;
  logic        FAstrobe = 1'b0;
  logic [5:0]  cellCount = '0;
  logic [7:0]  timeoutLimit = '0;

  // 2-link instance
  logic [1:0]  inhibit = '0, tvalid = '0, tuser = '0, tready;
  logic [13:0] tdata = '0;
  logic        mstrobe, ractive, rvalid, rtimeout, tstrobe, fen;
  logic [0:0]  mlink;
  logic [1:0]  mcode;
  logic [7:0]  rtime;
  logic [2:0]  seqno;
  logic [5:0]  ccount;
  logic [31:0] bm_all, bm_en, snap_all, snap_en;
  logic [11:0] lpc;

  // 4-link instance
  logic [3:0]  inhibit4 = '0, tvalid4 = '0, tuser4 = '0, tready4;
  logic [27:0] tdata4 = '0;
  logic        mstrobe4, ractive4, rvalid4, rtimeout4, tstrobe4, fen4;
  logic [1:0]  mlink4, mcode4;
  logic [7:0]  rtime4;
  logic [2:0]  seqno4;
  logic [5:0]  ccount4;
  logic [31:0] bm_all4, bm_en4, snap_all4, snap_en4;
  logic [23:0] lpc4;

  always #5 sysClk = ~sysClk;

  fofb_cell_tracker #(.SYSCLK_RATE(100000000), .NUM_LINKS(2), .MAX_CELLS(32)) dut (
    .sysClk(sysClk), .sysReset(sysReset), .FAstrobe(FAstrobe), .cellCount(cellCount),
    .timeoutLimit(timeoutLimit), .linkInhibit(inhibit), .statusTVALID(tvalid),
    .statusTREADY(tready), .statusTDATA(tdata), .statusTUSER(tuser),
    .mergedStrobe(mstrobe), .mergedLink(mlink), .mergedCode(mcode),
    .readoutActive(ractive), .readoutValid(rvalid), .readTimeout(rtimeout),
    .timeoutStrobe(tstrobe), .fofbEnabled(fen), .readoutTime(rtime), .seqno(seqno),
    .cellCounter(ccount), .fofbBitmapAll(bm_all), .fofbBitmapEnabled(bm_en),
    .fofbBitmapAllSnapshot(snap_all), .fofbBitmapEnabledSnapshot(snap_en),
    .linkPacketCount(lpc));

  fofb_cell_tracker #(.SYSCLK_RATE(100000000), .NUM_LINKS(4), .MAX_CELLS(32)) dut4 (
    .sysClk(sysClk), .sysReset(sysReset), .FAstrobe(FAstrobe), .cellCount(cellCount),
    .timeoutLimit(timeoutLimit), .linkInhibit(inhibit4), .statusTVALID(tvalid4),
    .statusTREADY(tready4), .statusTDATA(tdata4), .statusTUSER(tuser4),
    .mergedStrobe(mstrobe4), .mergedLink(mlink4), .mergedCode(mcode4),
    .readoutActive(ractive4), .readoutValid(rvalid4), .readTimeout(rtimeout4),
    .timeoutStrobe(tstrobe4), .fofbEnabled(fen4), .readoutTime(rtime4), .seqno(seqno4),
    .cellCounter(ccount4), .fofbBitmapAll(bm_all4), .fofbBitmapEnabled(bm_en4),
    .fofbBitmapAllSnapshot(snap_all4), .fofbBitmapEnabledSnapshot(snap_en4),
    .linkPacketCount(lpc4));

  // One beat on one link of the 2-link instance; returns at the negedge after the handshake.
  task automatic send_beat(input int link, input logic [1:0] code, input logic [4:0] idx, input logic user);
    int waited;
    tdata[link*SW +: SW] = {code, idx};
    tuser[link]  = user;
    tvalid[link] = 1'b1;
    waited = 0;
    #1;
    while (!tready[link] && waited < 8) begin
      @(negedge sysClk); #1; waited++;
    end
    checks++;
    if (!tready[link]) begin errors++; $display("FAIL beat_ready: link %0d ready got 0 expected 1", link); end
    @(negedge sysClk);
    tvalid[link] = 1'b0;
    $display("beat link=%0d code=%0d cell=%0d user=%0d", link, code, idx, user);
  endtask

  task automatic fa_pulse();
    FAstrobe = 1'b1;
    @(negedge sysClk);
    FAstrobe = 1'b0;
    $display("FAstrobe");
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sysClk);
    checks++; if (ractive !== 1'b0) begin errors++; $display("FAIL reset_active: got %0d expected 0", ractive); end
    checks++; if (seqno !== 3'd0) begin errors++; $display("FAIL reset_seqno: got %0d expected 0", seqno); end
    checks++; if (bm_all !== 32'h0) begin errors++; $display("FAIL reset_bitmap: got 0x%0h expected 0x0", bm_all); end
    checks++; if (lpc !== 12'h0) begin errors++; $display("FAIL reset_lpc: got 0x%0h expected 0x0", lpc); end
    checks++; if (mstrobe !== 1'b0) begin errors++; $display("FAIL reset_mstrobe: got %0d expected 0", mstrobe); end
    sysReset = 1'b0;
    @(negedge sysClk);
    $display("reset released");
  endtask

  task automatic test_arbitration();
    logic [3:0] exp_ready;
    tvalid4 = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      exp_ready = 4'b0001 << (i % 4);
      checks++;
      if (tready4 !== exp_ready) begin errors++; $display("FAIL arb_grant%0d: got 0x%0h expected 0x%0h", i, tready4, exp_ready); end
      if (i > 0) begin
        checks++;
        if (mstrobe4 !== 1'b1 || mlink4 !== 2'((i - 1) % 4)) begin
          errors++; $display("FAIL arb_merged%0d: got strobe=%0d link=%0d expected strobe=1 link=%0d", i, mstrobe4, mlink4, (i - 1) % 4);
        end
      end
      $display("arb cycle %0d ready=0x%0h", i, tready4);
      @(negedge sysClk);
    end
    tvalid4 = 4'h0;
  endtask

  task automatic test_complete();
    cellCount = 6'd3;
    timeoutLimit = 8'd0;
    fa_pulse();
    checks++; if (ractive !== 1'b1) begin errors++; $display("FAIL cpl_active: got %0d expected 1", ractive); end
    send_beat(0, 2'b00, 5'd0, 1'b1);
    checks++; if (mstrobe !== 1'b1 || mlink !== 1'b0 || mcode !== 2'b00) begin
      errors++; $display("FAIL cpl_merged0: got strobe=%0d link=%0d code=%0d expected 1/0/0", mstrobe, mlink, mcode); end
    send_beat(1, 2'b00, 5'd1, 1'b1);
    checks++; if (mlink !== 1'b1) begin errors++; $display("FAIL cpl_merged1: got link=%0d expected 1", mlink); end
    send_beat(0, 2'b00, 5'd2, 1'b1);
    repeat (2) @(negedge sysClk);
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL cpl_valid: got %0d expected 1", rvalid); end
    checks++; if (fen !== 1'b1) begin errors++; $display("FAIL cpl_fofb: got %0d expected 1", fen); end
    checks++; if (seqno !== 3'd1) begin errors++; $display("FAIL cpl_seqno: got %0d expected 1", seqno); end
    checks++; if (bm_all !== 32'h7) begin errors++; $display("FAIL cpl_bitmap: got 0x%0h expected 0x7", bm_all); end
    checks++; if (ractive !== 1'b0) begin errors++; $display("FAIL cpl_inactive: got %0d expected 0", ractive); end
    checks++; if (rtime !== 8'd0) begin errors++; $display("FAIL cpl_time: got %0d expected 0", rtime); end
    fa_pulse();
    checks++; if (snap_all !== 32'h7 || snap_en !== 32'h7) begin
      errors++; $display("FAIL cpl_snapshot: got all=0x%0h en=0x%0h expected 0x7/0x7", snap_all, snap_en); end
    checks++; if (lpc !== 12'h042) begin errors++; $display("FAIL cpl_lpc: got 0x%0h expected 0x042", lpc); end
    checks++; if (bm_all !== 32'h0 || rvalid !== 1'b0) begin
      errors++; $display("FAIL cpl_restart: got bitmap=0x%0h valid=%0d expected 0x0/0", bm_all, rvalid); end
  endtask

  task automatic test_duplicate();
    send_beat(0, 2'b00, 5'd5, 1'b1);
    send_beat(1, 2'b00, 5'd5, 1'b1);
    send_beat(0, 2'b00, 5'd5, 1'b0);
    repeat (2) @(negedge sysClk);
    checks++; if (ccount !== 6'd1) begin errors++; $display("FAIL dup_counter: got %0d expected 1", ccount); end
    checks++; if (bm_all !== 32'h20 || bm_en !== 32'h20) begin
      errors++; $display("FAIL dup_bitmap: got all=0x%0h en=0x%0h expected 0x20/0x20", bm_all, bm_en); end
    checks++; if (ractive !== 1'b1) begin errors++; $display("FAIL dup_active: got %0d expected 1", ractive); end
    fa_pulse();
    checks++; if (lpc !== 12'h042) begin errors++; $display("FAIL dup_lpc: got 0x%0h expected 0x042", lpc); end
    checks++; if (snap_all !== 32'h20) begin errors++; $display("FAIL dup_snapshot: got 0x%0h expected 0x20", snap_all); end
  endtask

  task automatic test_timeout();
    time t0;
    int  elapsed;
    bit  seen;
    timeoutLimit = 8'd10;
    cellCount = 6'd3;
    fa_pulse();
    t0 = $time;
    send_beat(0, 2'b00, 5'd0, 1'b1);
    send_beat(1, 2'b00, 5'd1, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 1300 && !seen; i++) begin
      @(negedge sysClk);
      if (tstrobe === 1'b1) seen = 1'b1;
    end
    elapsed = int'(($time - t0) / 10);
    $display("timeout strobe after %0d cycles", elapsed);
    checks++; if (!seen || elapsed < 900 || elapsed > 1100) begin
      errors++; $display("FAIL to_when: got seen=%0d cycles=%0d expected 900..1100", seen, elapsed); end
    checks++; if (rtimeout !== 1'b1 || fen !== 1'b0) begin
      errors++; $display("FAIL to_flags: got timeout=%0d fofb=%0d expected 1/0", rtimeout, fen); end
    checks++; if (rtime !== 8'd10) begin errors++; $display("FAIL to_time: got %0d expected 10", rtime); end
    checks++; if (seqno !== 3'd1 || rvalid !== 1'b0) begin
      errors++; $display("FAIL to_seqno: got seqno=%0d valid=%0d expected 1/0", seqno, rvalid); end
    checks++; if (ractive !== 1'b0 || ccount !== 6'd2) begin
      errors++; $display("FAIL to_state: got active=%0d cells=%0d expected 0/2", ractive, ccount); end
    @(negedge sysClk);
    checks++; if (tstrobe !== 1'b0) begin errors++; $display("FAIL to_pulse: got %0d expected 0", tstrobe); end
    timeoutLimit = 8'd0;
  endtask

  task automatic test_inhibit();
    inhibit = 2'b10;
    fa_pulse();
    tdata = {2'b00, 5'd4, 2'b00, 5'd3};
    tuser = 2'b11;
    tvalid = 2'b11;
    #1;
    checks++; if (tready !== 2'b11) begin errors++; $display("FAIL inh_ready_both: got 0x%0h expected 0x3", tready); end
    @(negedge sysClk);
    tvalid = 2'b00;
    $display("beat pair link0 cell=3, link1 cell=4 (inhibited)");
    checks++; if (mstrobe !== 1'b1 || mlink !== 1'b0) begin
      errors++; $display("FAIL inh_merged: got strobe=%0d link=%0d expected 1/0", mstrobe, mlink); end
    tdata[13:7] = {2'b00, 5'd6};
    tvalid = 2'b10;
    #1;
    checks++; if (tready !== 2'b10) begin errors++; $display("FAIL inh_ready1: got 0x%0h expected 0x2", tready); end
    @(negedge sysClk);
    tvalid = 2'b00;
    $display("beat link=1 cell=6 (inhibited)");
    checks++; if (mstrobe !== 1'b0) begin errors++; $display("FAIL inh_nostrobe: got %0d expected 0", mstrobe); end
    @(negedge sysClk);
    checks++; if (bm_all !== 32'h08 || ccount !== 6'd1) begin
      errors++; $display("FAIL inh_bitmap: got 0x%0h cells=%0d expected 0x8/1", bm_all, ccount); end
    inhibit = 2'b00;
  endtask

  task automatic test_fa_collision();
    tdata[6:0] = {2'b00, 5'd7};
    tuser[0] = 1'b1;
    tvalid[0] = 1'b1;
    @(negedge sysClk);
    tvalid[0] = 1'b0;
    $display("beat link=0 cell=7 colliding with FAstrobe");
    checks++; if (mstrobe !== 1'b1) begin errors++; $display("FAIL col_strobe: got %0d expected 1", mstrobe); end
    fa_pulse();
    checks++; if (snap_all !== 32'h08) begin errors++; $display("FAIL col_snapshot: got 0x%0h expected 0x8", snap_all); end
    checks++; if (bm_all !== 32'h0 || ccount !== 6'd0) begin
      errors++; $display("FAIL col_untracked: got 0x%0h cells=%0d expected 0x0/0", bm_all, ccount); end
    checks++; if (lpc !== 12'h001) begin errors++; $display("FAIL col_lpc: got 0x%0h expected 0x001", lpc); end
  endtask

  task automatic test_zero_count();
    cellCount = 6'd0;
    fa_pulse();
    checks++; if (ractive !== 1'b1 || rvalid !== 1'b0) begin
      errors++; $display("FAIL zero_start: got active=%0d valid=%0d expected 1/0", ractive, rvalid); end
    @(negedge sysClk);
    checks++; if (rvalid !== 1'b1 || ractive !== 1'b0 || fen !== 1'b1) begin
      errors++; $display("FAIL zero_done: got valid=%0d active=%0d fofb=%0d expected 1/0/1", rvalid, ractive, fen); end
    checks++; if (seqno !== 3'd2) begin errors++; $display("FAIL zero_seqno: got %0d expected 2", seqno); end
    send_beat(0, 2'b00, 5'd9, 1'b1);
    checks++; if (mstrobe !== 1'b1) begin errors++; $display("FAIL done_strobe: got %0d expected 1", mstrobe); end
    @(negedge sysClk);
    checks++; if (bm_all !== 32'h0 || ccount !== 6'd0) begin
      errors++; $display("FAIL done_untracked: got 0x%0h cells=%0d expected 0x0/0", bm_all, ccount); end
  endtask

  task automatic test_code_and_reset();
    cellCount = 6'd3;
    fa_pulse();
    send_beat(0, 2'b01, 5'd4, 1'b1);
    checks++; if (mcode !== 2'b01) begin errors++; $display("FAIL code_out: got %0d expected 1", mcode); end
    send_beat(0, 2'b00, 5'd1, 1'b1);
    @(negedge sysClk);
    checks++; if (bm_all !== 32'h02) begin errors++; $display("FAIL code_bitmap: got 0x%0h expected 0x2", bm_all); end
    sysReset = 1'b1;
    @(negedge sysClk);
    $display("sysReset mid-cycle");
    checks++; if (ractive !== 1'b0 || bm_all !== 32'h0 || ccount !== 6'd0) begin
      errors++; $display("FAIL rst_state: got active=%0d bitmap=0x%0h cells=%0d expected 0", ractive, bm_all, ccount); end
    checks++; if (seqno !== 3'd0 || rvalid !== 1'b0 || fen !== 1'b0) begin
      errors++; $display("FAIL rst_flags: got seqno=%0d valid=%0d fofb=%0d expected 0", seqno, rvalid, fen); end
    checks++; if (snap_all !== 32'h0 || lpc !== 12'h0 || mcode !== 2'b00) begin
      errors++; $display("FAIL rst_snap: got snap=0x%0h lpc=0x%0h code=%0d expected 0", snap_all, lpc, mcode); end
    sysReset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_complete();
    test_duplicate();
    test_timeout();
    test_inhibit();
    test_fa_collision();
    test_zero_count();
    test_code_and_reset();
    repeat (2) @(negedge sysClk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
